// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect sequencer: merges exception / mispredict / predictor redirects and drives fetch STALL, Alt_PC and IF/ID squash.
// Latency: a redirect seen at a free-slot edge appears on Request_Alt_PC/Alt_PC in the next cycle (registered outputs).
// Backpressure: when Pipe_Stall or !IM_Ready blocks the slot, the highest-class redirect is held and fetch is frozen until it issues.
//
// Ports: CLK, RESET (async, active-high); Pipe_Stall, IM_Ready (issue slot);
//        Exception, Mispredict/Mispredict_PC, Pred_Taken/Pred_Target (redirect sources);
//        STALL_OUT (combinational), Request_Alt_PC, Alt_PC, Flush_IFID, Pending (registered).
// Optional macro FETCH_REDIRECT_STATS_EN adds saturating Misp_Count / Exc_Count outputs.
module fetch_redirect_ctrl #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Pipe_Stall,
    input  logic        IM_Ready,
    input  logic        Exception,
    input  logic        Mispredict,
    input  logic [31:0] Mispredict_PC,
    input  logic        Pred_Taken,
    input  logic [31:0] Pred_Target,
    output logic        STALL_OUT,
    output logic        Request_Alt_PC,
    output logic [31:0] Alt_PC,
    output logic        Flush_IFID,
    output logic        Pending
`ifdef FETCH_REDIRECT_STATS_EN
    ,
    output logic [15:0] Misp_Count,
    output logic [15:0] Exc_Count
`endif
);

    localparam logic [1:0] CLS_NONE = 2'd0;
    localparam logic [1:0] CLS_PRED = 2'd1;
    localparam logic [1:0] CLS_MISP = 2'd2;
    localparam logic [1:0] CLS_EXC  = 2'd3;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [1:0]  cls_q;
    logic [1:0]  cls_d;
    logic [31:0] tgt_q;
    logic [31:0] tgt_d;

    logic        slot_free;
    logic [1:0]  in_cls;
    logic [31:0] in_tgt;
    logic [1:0]  win_cls;
    logic [31:0] win_tgt;

    logic        req_d;
    logic [31:0] pc_d;
    logic        flush_d;

    assign slot_free = ~Pipe_Stall & IM_Ready;

    // Highest-priority incoming redirect this cycle.
    always_comb begin
        in_cls = CLS_NONE;
        in_tgt = '0;
        if (Exception) begin
            in_cls = CLS_EXC;
            in_tgt = EXC_VECTOR;
        end else if (Mispredict) begin
            in_cls = CLS_MISP;
            in_tgt = Mispredict_PC;
        end else if (Pred_Taken) begin
            in_cls = CLS_PRED;
            in_tgt = Pred_Target;
        end
    end

    // The latched redirect survives ties; only a strictly higher class replaces it.
    // Outside HOLD cls_q is always CLS_NONE, so this reduces to the incoming one.
    always_comb begin
        win_cls = cls_q;
        win_tgt = tgt_q;
        if (in_cls > cls_q) begin
            win_cls = in_cls;
            win_tgt = in_tgt;
        end
    end

    // State register
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if ((win_cls != CLS_NONE) && !slot_free) state_d = ST_HOLD;
            ST_HOLD: if (slot_free) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // Output logic: next values of the registered outputs and the latch.
    always_comb begin
        req_d   = 1'b0;
        pc_d    = Alt_PC;
        flush_d = 1'b0;
        cls_d   = cls_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_BOOT: begin
                req_d = 1'b1;
                pc_d  = RESET_VECTOR;
            end
            ST_RUN, ST_HOLD: begin
                if (win_cls != CLS_NONE) begin
                    if (slot_free) begin
                        req_d   = 1'b1;
                        pc_d    = win_tgt;
                        flush_d = (win_cls >= CLS_MISP);
                        cls_d   = CLS_NONE;
                        tgt_d   = '0;
                    end else begin
                        cls_d = win_cls;
                        tgt_d = win_tgt;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cls_q          <= CLS_NONE;
            tgt_q          <= '0;
            Request_Alt_PC <= 1'b0;
            Alt_PC         <= '0;
            Flush_IFID     <= 1'b0;
            Pending        <= 1'b0;
        end else begin
            cls_q          <= cls_d;
            tgt_q          <= tgt_d;
            Request_Alt_PC <= req_d;
            Alt_PC         <= pc_d;
            Flush_IFID     <= flush_d;
            Pending        <= (cls_d != CLS_NONE);
        end
    end

    // BOOT term keeps fetch frozen while in reset and until the boot vector loads.
    assign STALL_OUT = Pipe_Stall | ~IM_Ready | (state_q == ST_HOLD) | (state_q == ST_BOOT);

`ifdef FETCH_REDIRECT_STATS_EN
    logic issue_redirect;
    assign issue_redirect = (state_q != ST_BOOT) && slot_free && (win_cls != CLS_NONE);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Misp_Count <= '0;
            Exc_Count  <= '0;
        end else if (issue_redirect) begin
            if ((win_cls == CLS_MISP) && (Misp_Count != 16'hFFFF)) Misp_Count <= Misp_Count + 16'd1;
            if ((win_cls == CLS_EXC) && (Exc_Count != 16'hFFFF)) Exc_Count <= Exc_Count + 16'd1;
        end
    end
`endif

endmodule
